// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the post-capture UART decoder: capture geometry and
// the state encodings of the word-walk FSM and the per-sample frame decoder.
// -----------------------------------------------------------------------------
package capture_pkg;

   localparam int CAP_WORDS   = 32;
   localparam int CAP_WORD_W  = 32;
   localparam int CAP_SAMPLES = 1024;

   // Word walk through the capture BRAM
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      LOAD,
      BITS,
      DONE
   } main_state_t;

   // Frame decoder, advanced once per capture sample
   typedef enum logic [2:0] {
      HUNT,
      START,
      DATA,
      PARITY,
      STOP
   } dec_state_t;

endpackage

// File: rtl/decode_byte_fifo.sv
// -----------------------------------------------------------------------------
// decode_byte_fifo
// Synchronous first-word-fall-through byte FIFO holding decoded UART bytes.
//   clk, reset_n : clock, synchronous active-low reset (pointers only)
//   push, din    : write request and byte; ignored when full unless popping
//   full         : no free entry
//   pop          : remove head; ignored when empty
//   dout         : current head, 0 while empty
//   empty        : no entry held
// -----------------------------------------------------------------------------
module decode_byte_fifo
   import capture_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  logic [7:0] din,
   output logic       full,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_pop;
   logic        do_push;

   // Extra pointer bit tells full from empty when the indices coincide.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/capture_uart_decoder.sv
// -----------------------------------------------------------------------------
// capture_uart_decoder
// Walks a completed 1024-sample capture (32 x 32-bit BRAM words, word 0 and
// bit 0 first), decodes asynchronous serial frames from it and queues the
// bytes for the bus slave. Acknowledges the capture unit when the walk ends.
//   clk, reset_n   : clock, synchronous active-low reset
//   enable         : arms decoding from idle
//   capture_ready  : capture complete level; its rising edge starts a walk
//   capture_ack    : one-cycle pulse at the end of a walk
//   bram_raddr     : registered BRAM word address
//   bram_rdata     : BRAM data, one cycle after the address
//   byte_valid     : decoded byte available
//   byte_data      : head byte (first-word-fall-through)
//   byte_rd        : pop the head byte
//   busy           : walk in progress
//   overflow       : sticky, a decoded byte was dropped on a full FIFO
//   frame_err_cnt  : saturating stop-bit error count
//   parity_err_cnt : saturating parity error count (parity build only)
// Build option: define CAPTURE_DECODER_PARITY_EN for 8E1 frames; the default
// build decodes 8N1 and has no parity_err_cnt port.
// -----------------------------------------------------------------------------
module capture_uart_decoder
   import capture_pkg::*;
#(
   parameter int SAMPLES_PER_BIT = 8,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        capture_ready,
   output logic        capture_ack,
   output logic [4:0]  bram_raddr,
   input  logic [31:0] bram_rdata,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   input  logic        byte_rd,
   output logic        busy,
   output logic        overflow,
   output logic [7:0]  frame_err_cnt
`ifdef CAPTURE_DECODER_PARITY_EN
   ,
   output logic [7:0]  parity_err_cnt
`endif
);

   localparam int BIT_IDX_W  = $clog2(CAP_WORD_W);
   localparam int WORD_IDX_W = $clog2(CAP_SAMPLES) - BIT_IDX_W;
   localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(CAP_WORD_W - 1);
   localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(CAP_WORDS - 1);
   localparam logic [6:0] SPB  = 7'(SAMPLES_PER_BIT);
   localparam logic [6:0] HALF = 7'(SAMPLES_PER_BIT / 2);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   main_state_t            state;
   logic                   ready_q;
   logic [WORD_IDX_W-1:0]  word_idx;
   logic [BIT_IDX_W-1:0]   bit_idx;
   logic [CAP_WORD_W-1:0]  word_reg;
   logic                   accept;
   logic                   step;
   logic                   sample;

   dec_state_t             dstate;
   logic [6:0]             cnt;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic                   prev;
   logic                   push;
   logic                   fifo_full;
   logic                   fifo_empty;
`ifdef CAPTURE_DECODER_PARITY_EN
   logic                   par_bad;
`endif

   assign accept = (state == IDLE) && enable && capture_ready && !ready_q;
   assign step   = (state == BITS);
   assign sample = word_reg[bit_idx];

   // Good stop bit at the stop sample point delivers the assembled byte.
`ifdef CAPTURE_DECODER_PARITY_EN
   assign push = step && (dstate == STOP) && (cnt == SPB) && sample && !par_bad;
`else
   assign push = step && (dstate == STOP) && (cnt == SPB) && sample;
`endif

   // ---- word walk: FETCH -> WAIT -> LOAD -> 32 x BITS per word ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         ready_q     <= 1'b1;   // a level already high out of reset is not a rise
         word_idx    <= '0;
         bit_idx     <= '0;
         bram_raddr  <= '0;
         busy        <= 1'b0;
         capture_ack <= 1'b0;
      end else begin
         ready_q     <= capture_ready;
         capture_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  word_idx <= '0;
                  busy     <= 1'b1;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               bram_raddr <= word_idx;
               state      <= WAIT;
            end
            WAIT: state <= LOAD;
            LOAD: begin
               bit_idx <= '0;
               state   <= BITS;
            end
            BITS: begin
               bit_idx <= bit_idx + 1'b1;
               if (bit_idx == LAST_BIT) begin
                  if (word_idx == LAST_WORD) begin
                     capture_ack <= 1'b1;
                     state       <= DONE;
                  end else begin
                     word_idx <= word_idx + 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == LOAD) word_reg <= bram_rdata;
   end

   // ---- frame decoder: one step per sample while walking ----
   // cnt counts samples since the last decision point; the start bit is
   // confirmed at mid-bit and every later bit is sampled a full bit apart.
   always_ff @(posedge clk) begin
      if (!reset_n || accept) begin
         dstate        <= HUNT;
         cnt           <= '0;
         bit_cnt       <= '0;
         prev          <= 1'b1;
         overflow      <= 1'b0;
         frame_err_cnt <= '0;
`ifdef CAPTURE_DECODER_PARITY_EN
         par_bad        <= 1'b0;
         parity_err_cnt <= '0;
`endif
      end else begin
         if (push && fifo_full && !byte_rd) overflow <= 1'b1;
         if (step) begin
            case (dstate)
               HUNT: begin
                  prev <= sample;
                  if (!sample && prev) begin
                     cnt    <= 7'd1;
                     dstate <= START;
                  end
               end
               START: begin
                  if (cnt == HALF) begin
                     if (!sample) begin
                        cnt     <= 7'd1;
                        bit_cnt <= '0;
                        dstate  <= DATA;
                     end else begin
                        // Too short to be a start bit: resume hunting on a high line.
                        prev   <= 1'b1;
                        dstate <= HUNT;
                     end
                  end else begin
                     cnt <= cnt + 7'd1;
                  end
               end
               DATA: begin
                  if (cnt == SPB) begin
                     shreg   <= {sample, shreg[7:1]};
                     cnt     <= 7'd1;
                     bit_cnt <= bit_cnt + 3'd1;
`ifdef CAPTURE_DECODER_PARITY_EN
                     if (bit_cnt == 3'd7) dstate <= PARITY;
`else
                     if (bit_cnt == 3'd7) dstate <= STOP;
`endif
                  end else begin
                     cnt <= cnt + 7'd1;
                  end
               end
`ifdef CAPTURE_DECODER_PARITY_EN
               PARITY: begin
                  if (cnt == SPB) begin
                     par_bad <= ^{shreg, sample};
                     cnt     <= 7'd1;
                     dstate  <= STOP;
                  end else begin
                     cnt <= cnt + 7'd1;
                  end
               end
`endif
               STOP: begin
                  if (cnt == SPB) begin
                     prev   <= sample;
                     dstate <= HUNT;
                     if (!sample) frame_err_cnt <= sat_inc(frame_err_cnt);
`ifdef CAPTURE_DECODER_PARITY_EN
                     if (par_bad) parity_err_cnt <= sat_inc(parity_err_cnt);
`endif
                  end else begin
                     cnt <= cnt + 7'd1;
                  end
               end
               default: dstate <= HUNT;
            endcase
         end
      end
   end

   decode_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (shreg),
      .full    (fifo_full),
      .pop     (byte_rd),
      .dout    (byte_data),
      .empty   (fifo_empty)
   );

   assign byte_valid = !fifo_empty;

endmodule
